// File: rtl/spectrum_streamer_if.sv
// Spectrum streamer bus: FFT bin input side,
// estimator-facing burst output and completion pulse.
interface spectrum_streamer_if #(
  parameter int BIT_WIDTH = 32,
  parameter int FFT_N     = 1024,
  parameter int IN_WIDTH  = 16
);
  localparam int IW = $clog2(FFT_N);

  logic                       bin_valid;
  logic [IW-1:0]              bin_index;
  logic signed [IN_WIDTH-1:0] bin_re;
  logic signed [IN_WIDTH-1:0] bin_im;
  logic                       bin_last;
  logic                       ds_done;
  logic                       fft_valid;
  logic [BIT_WIDTH-1:0]       fft_data;

  modport master (
    output bin_valid, bin_index, bin_re, bin_im,
    output bin_last, ds_done,
    input  fft_valid, fft_data
  );

  modport slave (
    input  bin_valid, bin_index, bin_re, bin_im,
    input  bin_last, ds_done,
    output fft_valid, fft_data
  );
endinterface

// File: rtl/spectrum_streamer.sv
// FFT bin -> power, ping-pong frame buffer, paced burst replay.
// Optional ds_done timeout: define SPECTRUM_STREAMER_TIMEOUT_EN.
module spectrum_streamer #(
  parameter int BIT_WIDTH  = 32,
  parameter int I          = 160,
  parameter int FFT_N      = 1024,
  parameter int IN_WIDTH   = 16,
  parameter int DS_TIMEOUT = 2000000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  spectrum_streamer_if.slave    io,
  output logic [7:0]            frames_dropped,
  output logic                  busy
`ifdef SPECTRUM_STREAMER_TIMEOUT_EN
  ,
  output logic                  ds_timeout
`endif
);
  localparam int IW = $clog2(FFT_N);
  localparam int AW = $clog2(I);
  localparam int PW = 2 * IN_WIDTH;
  localparam int SW = PW + 1;

  if (DS_TIMEOUT < 1 || I > FFT_N) begin : g_param_chk
    $error("spectrum_streamer: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE, PREFETCH, SEND, WAIT_DS
  } state_t;

  state_t state_q, state_d;
  logic pf_q, pf_d;
  logic [AW-1:0] beat_q, beat_d;
  logic [AW-1:0] rd_q, rd_d;

  logic s1_valid_q, s1_valid_d;
  logic s1_last_q, s1_last_d;
  logic [IW-1:0] s1_idx_q, s1_idx_d;
  logic signed [PW-1:0] sq_re_q, sq_re_d;
  logic signed [PW-1:0] sq_im_q, sq_im_d;

  logic s2_valid_q, s2_valid_d;
  logic s2_last_q, s2_last_d;
  logic [IW-1:0] s2_idx_q, s2_idx_d;
  logic [BIT_WIDTH-1:0] s2_pow_q, s2_pow_d;
  logic [SW-1:0] sum;
  logic sat;

  logic send_sel_q, send_sel_d;
  logic send_full_q, send_full_d;
  logic [7:0] drop_q, drop_d;
  logic fft_valid_q, fft_valid_d;
  logic [BIT_WIDTH-1:0] fft_data_q, fft_data_d;
  logic [BIT_WIDTH-1:0] rdata_q;

  logic wr_en, commit, send_done, accept, ds_ev;

  logic [BIT_WIDTH-1:0] mem [2][I];

  // Two-stage power pipeline; sums past the signed
  // result range clamp to all ones.
  always_comb begin
    s1_valid_d = io.bin_valid;
    s1_last_d  = io.bin_valid & io.bin_last;
    s1_idx_d   = io.bin_index;
    sq_re_d    = PW'(io.bin_re) * PW'(io.bin_re);
    sq_im_d    = PW'(io.bin_im) * PW'(io.bin_im);
    sum        = {1'b0, sq_re_q} + {1'b0, sq_im_q};
    sat        = (sum >> (BIT_WIDTH - 1)) != '0;
    s2_valid_d = s1_valid_q;
    s2_last_d  = s1_last_q;
    s2_idx_d   = s1_idx_q;
    s2_pow_d   = sat ? '1 : BIT_WIDTH'(sum);
  end

  // Commit/swap/drop bookkeeping for the ping-pong banks.
  always_comb begin
    wr_en     = s2_valid_q && (s2_idx_q < IW'(I));
    commit    = s2_valid_q && s2_last_q;
    send_done = (state_q == SEND)
              && (beat_q == AW'(I - 1));
    accept    = commit && (!send_full_q || send_done);
    send_sel_d  = send_sel_q;
    send_full_d = send_full_q;
    drop_d      = drop_q;
    if (send_done) send_full_d = 1'b0;
    if (accept) begin
      send_sel_d  = ~send_sel_q;
      send_full_d = 1'b1;
    end
    if (commit && !accept && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  // Send FSM: read-latency prefetch, gap-free burst, then
  // hold until the estimator signals completion.
  always_comb begin
    state_d     = state_q;
    pf_d        = pf_q;
    beat_d      = beat_q;
    rd_d        = rd_q;
    fft_valid_d = 1'b0;
    fft_data_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (send_full_q || accept) begin
          state_d = PREFETCH;
          pf_d    = 1'b0;
          rd_d    = '0;
        end
      end
      PREFETCH: begin
        rd_d = rd_q + 1'b1;
        pf_d = 1'b1;
        if (pf_q) begin
          state_d     = SEND;
          beat_d      = '0;
          fft_valid_d = 1'b1;
          fft_data_d  = rdata_q;
        end
      end
      SEND: begin
        if (rd_q != AW'(I - 1)) rd_d = rd_q + 1'b1;
        if (send_done) begin
          state_d = WAIT_DS;
        end else begin
          beat_d      = beat_q + 1'b1;
          fft_valid_d = 1'b1;
          fft_data_d  = rdata_q;
        end
      end
      WAIT_DS: begin
        if (ds_ev) begin
          if (send_full_q || accept) begin
            state_d = PREFETCH;
            pf_d    = 1'b0;
            rd_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // Control and pipeline registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      pf_q        <= 1'b0;
      beat_q      <= '0;
      rd_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_idx_q    <= '0;
      sq_re_q     <= '0;
      sq_im_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_idx_q    <= '0;
      s2_pow_q    <= '0;
      send_sel_q  <= 1'b0;
      send_full_q <= 1'b0;
      drop_q      <= '0;
      fft_valid_q <= 1'b0;
      fft_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pf_q        <= pf_d;
      beat_q      <= beat_d;
      rd_q        <= rd_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_idx_q    <= s1_idx_d;
      sq_re_q     <= sq_re_d;
      sq_im_q     <= sq_im_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_idx_q    <= s2_idx_d;
      s2_pow_q    <= s2_pow_d;
      send_sel_q  <= send_sel_d;
      send_full_q <= send_full_d;
      drop_q      <= drop_d;
      fft_valid_q <= fft_valid_d;
      fft_data_q  <= fft_data_d;
    end
  end

  // Bank RAM: capture writes one bank, replay reads the other.
  always_ff @(posedge clk_in) begin
    if (wr_en)
      mem[~send_sel_q][s2_idx_q[AW-1:0]] <= s2_pow_q;
    rdata_q <= mem[send_sel_q][rd_q];
  end

`ifdef SPECTRUM_STREAMER_TIMEOUT_EN
  localparam int TW = $clog2(DS_TIMEOUT + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic to_flag_q, to_flag_d;
  logic to_hit;

  // Give up on a silent estimator after DS_TIMEOUT cycles.
  always_comb begin
    to_hit = (state_q == WAIT_DS) && !io.ds_done
           && (to_cnt_q == TW'(DS_TIMEOUT - 1));
    to_cnt_d  = (state_q == WAIT_DS)
              ? to_cnt_q + 1'b1 : '0;
    to_flag_d = to_flag_q | to_hit;
    ds_ev     = io.ds_done | to_hit;
  end

  // Timeout counter and sticky flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign ds_timeout = to_flag_q;
`else
  assign ds_ev = io.ds_done;
`endif

  assign io.fft_valid    = fft_valid_q;
  assign io.fft_data     = fft_data_q;
  assign frames_dropped  = drop_q;
  assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_spectrum_streamer.sv
// Directed bench for spectrum_streamer: power table,
// burst timing, overlap/drop, simultaneous events, reset.
module tb_spectrum_streamer;
  localparam int BW    = 32;
  localparam int NI    = 160;
  localparam int FN    = 1024;
  localparam int INW   = 16;
  localparam int DS_TO = 100;
  localparam int IW    = $clog2(FN);
  localparam int NV    = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spectrum_streamer_if #(
    .BIT_WIDTH(BW), .FFT_N(FN), .IN_WIDTH(INW)
  ) io ();

  logic [7:0] frames_dropped;
  logic       busy;
`ifdef SPECTRUM_STREAMER_TIMEOUT_EN
  logic       ds_timeout;
`endif

  spectrum_streamer #(
    .BIT_WIDTH(BW), .I(NI), .FFT_N(FN),
    .IN_WIDTH(INW), .DS_TIMEOUT(DS_TO)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .io(io),
    .frames_dropped(frames_dropped),
    .busy(busy)
`ifdef SPECTRUM_STREAMER_TIMEOUT_EN
    ,
    .ds_timeout(ds_timeout)
`endif
  );

  typedef struct {
    logic signed [INW-1:0] re;
    logic signed [INW-1:0] im;
    logic [BW-1:0]         pw;
  } vec_t;

  vec_t tab [NV];

  int tests = 0;
  int fails = 0;

  logic [BW-1:0] bq [$];
  int            cq [$];

  // Record every burst beat with its cycle stamp.
  always @(negedge clk)
    if (io.fft_valid === 1'b1) begin
      bq.push_back(io.fft_data);
      cq.push_back(cyc);
    end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] expv(
    input int tag, input bit use_tab, input int k);
    if (use_tab && k < NV) return tab[k].pw;
    return BW'((k + tag) * (k + tag));
  endfunction

  task automatic drive_frame(input int nb, input int tag,
                             input bit use_tab,
                             input bit ds_sim,
                             output int last_cyc);
    last_cyc = 0;
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      io.bin_valid = 1'b1;
      io.bin_index = IW'(k);
      if (use_tab && k < NV) begin
        io.bin_re = tab[k].re;
        io.bin_im = tab[k].im;
      end else begin
        io.bin_re = INW'(k + tag);
        io.bin_im = '0;
      end
      io.bin_last = (k == nb - 1);
      if (k == nb - 1) last_cyc = cyc;
    end
    @(negedge clk);
    io.bin_valid = 1'b0;
    io.bin_last  = 1'b0;
    if (ds_sim) begin
      @(negedge clk);
      io.ds_done = 1'b1;
      @(negedge clk);
      io.ds_done = 1'b0;
    end
  endtask

  task automatic check_burst(input string nm,
                             input int tag,
                             input bit use_tab,
                             input int start);
    int w;
    int bad;
    w = 0;
    while (bq.size() < NI && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (bq.size() < NI) begin
      chk({nm, "_beats"}, bq.size(), NI);
    end else begin
      chk({nm, "_start"}, cq[0], start);
      bad = 0;
      for (int k = 0; k < NI; k++)
        if (cq[k] != cq[0] + k) bad++;
      chk({nm, "_gaps"}, bad, 0);
      for (int k = 0; k < NI; k++)
        chk($sformatf("%s_d%0d", nm, k),
            bq[k], expv(tag, use_tab, k));
      repeat (4) @(negedge clk);
      chk({nm, "_len"}, bq.size(), NI);
    end
    bq.delete();
    cq.delete();
  endtask

  task automatic pulse_ds(output int at);
    @(negedge clk);
    at = cyc;
    io.ds_done = 1'b1;
    @(negedge clk);
    io.ds_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int la, lb, lc, d;
    tab[0] = '{ 16'sd0,      16'sd0,      32'h0000_0000};
    tab[1] = '{ 16'sd1,      16'sd0,      32'h0000_0001};
    tab[2] = '{-16'sd1,     -16'sd1,      32'h0000_0002};
    tab[3] = '{ 16'sd100,   -16'sd200,    32'd50000};
    tab[4] = '{ 16'sd32767,  16'sd32767,  32'h7FFE_0002};
    tab[5] = '{-16'sd32768, -16'sd32768,  32'hFFFF_FFFF};
    tab[6] = '{ 16'sd3,      16'sd4,      32'd25};
    tab[7] = '{-16'sd3,     -16'sd4,      32'd25};
    tab[8] = '{-16'sd32768,  16'sd0,      32'h4000_0000};
    tab[9] = '{-16'sd32768, -16'sd32767,  32'h7FFF_0001};

    io.bin_valid = 1'b0;
    io.bin_index = '0;
    io.bin_re    = '0;
    io.bin_im    = '0;
    io.bin_last  = 1'b0;
    io.ds_done   = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", io.fft_valid, 0);
    chk("rst_data", io.fft_data, 0);
    chk("rst_drop", frames_dropped, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    drive_frame(FN, 0, 1'b0, 1'b0, lc);
    check_burst("single", 0, 1'b0, lc + 5);
    chk("single_busy_a", busy, 1);
    repeat (5) @(negedge clk);
    chk("single_busy_b", busy, 1);
    pulse_ds(d);
    chk("single_idle", busy, 0);

    drive_frame(FN, 0, 1'b1, 1'b0, lc);
    check_burst("table", 0, 1'b1, lc + 5);
    pulse_ds(d);

`ifndef SPECTRUM_STREAMER_TIMEOUT_EN
    drive_frame(FN, 1, 1'b0, 1'b0, la);
    drive_frame(FN, 2, 1'b0, 1'b0, lb);
    drive_frame(FN, 3, 1'b0, 1'b0, lc);
    check_burst("ovl_a", 1, 1'b0, la + 5);
    chk("ovl_drop", frames_dropped, 1);
    chk("ovl_busy", busy, 1);
    pulse_ds(d);
    check_burst("ovl_b", 2, 1'b0, d + 3);
    pulse_ds(d);
    repeat (10) @(negedge clk);
    chk("ovl_c_held", bq.size(), 0);
    chk("ovl_idle", busy, 0);

    drive_frame(FN, 4, 1'b0, 1'b0, la);
    check_burst("sim_d", 4, 1'b0, la + 5);
    drive_frame(FN, 5, 1'b0, 1'b1, lb);
    check_burst("sim_e", 5, 1'b0, lb + 5);
    chk("sim_drop", frames_dropped, 1);
    pulse_ds(d);

    drive_frame(FN, 6, 1'b0, 1'b0, lc);
    while (cyc < lc + 85) @(negedge clk);
    chk("rb_pre_valid", io.fft_valid, 1);
    chk("rb_pre_data", io.fft_data, 86 * 86);
    #1 rst = 1'b1;
    #1;
    chk("rb_valid", io.fft_valid, 0);
    chk("rb_busy", busy, 0);
    chk("rb_drop", frames_dropped, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bq.delete();
    cq.delete();
    drive_frame(FN, 7, 1'b0, 1'b0, lc);
    check_burst("post_rst", 7, 1'b0, lc + 5);
    chk("post_rst_drop", frames_dropped, 0);
    pulse_ds(d);
`else
    drive_frame(NI, 8, 1'b0, 1'b0, la);
    while (cyc < la + 4) @(negedge clk);
    drive_frame(NI, 9, 1'b0, 1'b0, lb);
    check_burst("to_g", 8, 1'b0, la + 5);
    chk("to_flag_lo", ds_timeout, 0);
    check_burst("to_h", 9, 1'b0,
                la + 5 + NI - 1 + DS_TO + 3);
    chk("to_flag_hi", ds_timeout, 1);
    chk("to_drop", frames_dropped, 0);
`endif

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
